// File: rtl/intpol2_d4_out_fifo_pkg.sv
// Shared defaults and the almost-full threshold helper for the interpolator output FIFO.
// Optional error flags are enabled by INTPOL2_D4_FIFO_ERR_EN (see top level).
package intpol2_d4_out_fifo_pkg;

   localparam int DEF_DATA_WIDTH   = 32;
   localparam int DEF_DEPTH        = 16;
   localparam int DEF_AFULL_MARGIN = 4;

   // afull asserts once occupancy reaches this level, leaving margin for in-flight writes
   function automatic int afull_thresh(input int depth, input int margin);
      return depth - margin;
   endfunction

endpackage

// File: rtl/intpol2_d4_out_fifo_mem.sv
// Simple dual-port sample RAM: one write port, one registered read port.
// Read data appears one cycle after re and holds otherwise; it resets to zero.
module intpol2_d4_out_fifo_mem #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 16,
   parameter int AW         = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  we,
   input  logic [AW-1:0]         waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic                  re,
   input  logic [AW-1:0]         raddr,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] rdata_d, rdata_q;

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   always_comb begin
      rdata_d = rdata_q;
      if (re) begin
         rdata_d = mem_q[raddr];
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rdata_q <= '0;
      end else begin
         rdata_q <= rdata_d;
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/intpol2_d4_out_fifo.sv
// Output FIFO behind the interpolator: 1-cycle registered read, early afull for pipeline slack.
// Define INTPOL2_D4_FIFO_ERR_EN to add sticky ovf/udf error outputs.
module intpol2_d4_out_fifo
   import intpol2_d4_out_fifo_pkg::*;
#(
   parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
   parameter int DEPTH        = DEF_DEPTH,
   parameter int AFULL_MARGIN = DEF_AFULL_MARGIN
) (
   input  logic                       clk,
   input  logic                       rstn,
   input  logic                       clear,
   input  logic                       wr_en,
   input  logic [DATA_WIDTH-1:0]      wr_data,
   input  logic                       rd_en,
   output logic [DATA_WIDTH-1:0]      rd_data,
   output logic                       rd_valid,
   output logic                       empty,
   output logic                       full,
   output logic                       afull,
   output logic [$clog2(DEPTH):0]     count
`ifdef INTPOL2_D4_FIFO_ERR_EN
   ,
   output logic                       ovf,
   output logic                       udf
`endif
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_LVL = CW'(DEPTH);
   localparam logic [CW-1:0] AFULL_LVL = CW'(afull_thresh(DEPTH, AFULL_MARGIN));

   logic [PW-1:0] wr_ptr_d, wr_ptr_q, rd_ptr_d, rd_ptr_q;
   logic [CW-1:0] count_d, count_q;
   logic          empty_d, empty_q, full_d, full_q, afull_d, afull_q;
   logic          rd_valid_d, rd_valid_q;
   logic          wr_acc, rd_acc;

   // Flags are registered, so a write in the same cycle as a pop on a full FIFO is still dropped
   always_comb begin
      wr_acc   = wr_en & ~full_q & ~clear;
      rd_acc   = rd_en & ~empty_q & ~clear;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (clear) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (wr_acc) wr_ptr_d = wr_ptr_q + PW'(1);
         if (rd_acc) rd_ptr_d = rd_ptr_q + PW'(1);
         case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
      empty_d    = (count_d == '0);
      full_d     = (count_d == DEPTH_LVL);
      afull_d    = (count_d >= AFULL_LVL);
      rd_valid_d = rd_acc;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         empty_q    <= 1'b1;
         full_q     <= 1'b0;
         afull_q    <= 1'b0;
         rd_valid_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         empty_q    <= empty_d;
         full_q     <= full_d;
         afull_q    <= afull_d;
         rd_valid_q <= rd_valid_d;
      end
   end

   intpol2_d4_out_fifo_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
   ) u_mem (
      .clk   (clk),
      .rstn  (rstn),
      .we    (wr_acc),
      .waddr (wr_ptr_q),
      .wdata (wr_data),
      .re    (rd_acc),
      .raddr (rd_ptr_q),
      .rdata (rd_data)
   );

   assign rd_valid = rd_valid_q;
   assign empty    = empty_q;
   assign full     = full_q;
   assign afull    = afull_q;
   assign count    = count_q;

`ifdef INTPOL2_D4_FIFO_ERR_EN
   logic ovf_d, ovf_q, udf_d, udf_q;

   // Sticky until flushed; clear wins over a same-cycle error
   always_comb begin
      ovf_d = ovf_q | (wr_en & full_q);
      udf_d = udf_q | (rd_en & empty_q);
      if (clear) begin
         ovf_d = 1'b0;
         udf_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         ovf_q <= 1'b0;
         udf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
         udf_q <= udf_d;
      end
   end

   assign ovf = ovf_q;
   assign udf = udf_q;
`endif

endmodule
